// File: rtl/mult_div_unit_r0.sv
// Iterative multiply/divide unit that owns the architectural HI/LO registers.
// Shift-add multiply and restoring divide run one bit per cycle on magnitudes; signs are fixed up at the end.
module mult_div_unit_r0 #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALUFUNCT_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid,
  input  logic [ALUFUNCT_WIDTH-1:0] ALUfunct,
  input  logic [DATA_WIDTH-1:0]     rs_data,
  input  logic [DATA_WIDTH-1:0]     rt_data,
  output logic                      stall,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_valid
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [ALUFUNCT_WIDTH-1:0] F_MFHI  = ALUFUNCT_WIDTH'('h10);
  localparam logic [ALUFUNCT_WIDTH-1:0] F_MTHI  = ALUFUNCT_WIDTH'('h11);
  localparam logic [ALUFUNCT_WIDTH-1:0] F_MFLO  = ALUFUNCT_WIDTH'('h12);
  localparam logic [ALUFUNCT_WIDTH-1:0] F_MTLO  = ALUFUNCT_WIDTH'('h13);
  localparam logic [ALUFUNCT_WIDTH-1:0] F_MULT  = ALUFUNCT_WIDTH'('h18);
  localparam logic [ALUFUNCT_WIDTH-1:0] F_MULTU = ALUFUNCT_WIDTH'('h19);
  localparam logic [ALUFUNCT_WIDTH-1:0] F_DIV   = ALUFUNCT_WIDTH'('h1A);
  localparam logic [ALUFUNCT_WIDTH-1:0] F_DIVU  = ALUFUNCT_WIDTH'('h1B);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
    return ~v + 1'b1;
  endfunction

  // Magnitude of a two's-complement operand; the most negative value maps onto itself as unsigned.
  function automatic logic [W-1:0] mag(input logic signed [W-1:0] v, input logic is_signed);
    return (is_signed && v[W-1]) ? neg_w(v) : v;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_hi, r_lo;
  logic            r_done;
  logic [W-1:0]    r_acc_hi, r_acc_lo, r_opb;
  logic            r_is_div, r_neg_lo, r_neg_hi, r_dz;

  logic            w_mfhi, w_mthi, w_mflo, w_mtlo, w_md, w_signed, w_div, w_any, w_idle;
  logic [W:0]      w_mul_sum, w_div_sh;
  logic            w_div_ge;
  logic [W-1:0]    w_div_diff;
  logic [2*W-1:0]  w_prod_fix;
  logic [W-1:0]    w_fix_hi, w_fix_lo;

  assign w_mfhi   = valid && (ALUfunct == F_MFHI);
  assign w_mthi   = valid && (ALUfunct == F_MTHI);
  assign w_mflo   = valid && (ALUfunct == F_MFLO);
  assign w_mtlo   = valid && (ALUfunct == F_MTLO);
  assign w_md     = valid && ((ALUfunct == F_MULT) || (ALUfunct == F_MULTU) ||
                              (ALUfunct == F_DIV)  || (ALUfunct == F_DIVU));
  assign w_signed = (ALUfunct == F_MULT) || (ALUfunct == F_DIV);
  assign w_div    = (ALUfunct == F_DIV)  || (ALUfunct == F_DIVU);
  assign w_any    = w_md || w_mfhi || w_mthi || w_mflo || w_mtlo;
  assign w_idle   = (r_state == S_IDLE);

  assign busy     = !w_idle;
  assign stall    = w_any && busy;
  assign done     = r_done;
  assign rd_valid = (w_mfhi || w_mflo) && w_idle;
  assign rd_data  = !w_idle ? '0 : (w_mfhi ? r_hi : (w_mflo ? r_lo : '0));

  // One iteration step for each algorithm; only the one matching r_is_div is used.
  assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);
  assign w_div_sh   = {r_acc_hi, r_acc_lo[W-1]};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_opb});
  assign w_div_diff = w_div_sh[W-1:0] - r_opb;

  assign w_prod_fix = r_neg_lo ? neg_2w({r_acc_hi, r_acc_lo}) : {r_acc_hi, r_acc_lo};
  assign w_fix_hi   = r_is_div ? (r_neg_hi ? neg_w(r_acc_hi) : r_acc_hi) : w_prod_fix[2*W-1:W];
  assign w_fix_lo   = r_is_div ? (r_dz ? '1 : (r_neg_lo ? neg_w(r_acc_lo) : r_acc_lo))
                               : w_prod_fix[W-1:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_md) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CW'(1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (w_md)   r_cnt <= CW'(W);
          if (w_mthi) r_hi  <= rs_data;
          if (w_mtlo) r_lo  <= rs_data;
        end
        S_RUN:   r_cnt <= r_cnt - 1'b1;
        S_FIX: begin
          r_hi <= w_fix_hi;
          r_lo <= w_fix_lo;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Working registers carry no reset: they are always reloaded before use.
  always_ff @(posedge clk) begin
    if (w_idle && w_md) begin
      r_acc_hi <= '0;
      r_acc_lo <= mag(rs_data, w_signed);
      r_opb    <= mag(rt_data, w_signed);
      r_is_div <= w_div;
      r_neg_lo <= w_signed && (rs_data[W-1] ^ rt_data[W-1]);
      r_neg_hi <= w_signed && w_div && rs_data[W-1];
      r_dz     <= w_div && (rt_data == '0);
    end else if (r_state == S_RUN) begin
      if (r_is_div) begin
        r_acc_hi <= w_div_ge ? w_div_diff : w_div_sh[W-1:0];
        r_acc_lo <= {r_acc_lo[W-2:0], w_div_ge};
      end else begin
        r_acc_hi <= w_mul_sum[W:1];
        r_acc_lo <= {w_mul_sum[0], r_acc_lo[W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit_r0.sv
// Self-checking bench for mult_div_unit_r0: mfhi/mflo reads are scored against a queue of expected values.
module tb_mult_div_unit_r0;

  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;

  logic        clk = 1'b0;
  logic        rst, valid;
  logic [5:0]  funct;
  logic [31:0] rs, rt;
  logic        stall, busy, done, rd_valid;
  logic [31:0] rd_data;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mult_div_unit_r0 #(.DATA_WIDTH(32), .ALUFUNCT_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ALUfunct(funct),
    .rs_data(rs), .rt_data(rt), .stall(stall), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model returning {HI, LO}.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = 64'($signed(a));
    sb = 64'($signed(b));
    p  = '0;
    case (f)
      MULTU: p = {32'b0, a} * {32'b0, b};
      MULT:  p = sa * sb;
      DIVU:  p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) check("rd_unexpected", {31'b0, rd_valid}, 32'd0);
      else                   check("rd_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic read_hilo(input logic [31:0] hi, input logic [31:0] lo);
    @(posedge clk); #1; valid = 1'b1; funct = MFHI; exp_q.push_back(hi);
    @(posedge clk); #1; funct = MFLO; exp_q.push_back(lo);
    @(posedge clk); #1; valid = 1'b0; funct = 6'h00;
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo);
    int cyc;
    @(posedge clk); #1; valid = 1'b1; funct = f; rs = a; rt = b;
    @(negedge clk); check("stall_at_issue", {31'b0, stall}, 32'd0);
    @(posedge clk); #1; valid = 1'b0; funct = 6'h00;
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("busy_cycles", cyc, 32'd33);
    check("done_pulse", {31'b0, done}, 32'd1);
    read_hilo(hi, lo);
    @(negedge clk); check("done_cleared", {31'b0, done}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic bad, seen;
    logic [5:0] f;
    logic [31:0] a, b;
    logic [63:0] m;
    rst = 1'b1; valid = 1'b0; funct = 6'h00; rs = '0; rt = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    read_hilo(32'd0, 32'd0);

    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op(DIV,   32'hFFFF_FF00, 32'd0,         32'hFFFF_FF00, 32'hFFFF_FFFF);

    for (int i = 0; i < 12; i++) begin
      case (i % 4)
        0: f = MULT;
        1: f = MULTU;
        2: f = DIV;
        default: f = DIVU;
      endcase
      a = $urandom;
      b = (i >= 8) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i >= 8 && (i % 2) == 0) b = -b;
      m = model(f, a, b);
      run_op(f, a, b, m[63:32], m[31:0]);
    end

    // mfhi held from the cycle after a multiply is accepted
    @(posedge clk); #1; valid = 1'b1; funct = MULTU; rs = 32'h0001_0000; rt = 32'h0003_0000;
    @(posedge clk); #1; funct = MFHI; exp_q.push_back(32'h0000_0003);
    bad = 1'b0; cyc = 0;
    @(negedge clk);
    while (busy && cyc < 100) begin
      if (stall !== 1'b1 || rd_valid !== 1'b0) bad = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check("mfhi_wait_cycles", cyc, 32'd33);
    check("mfhi_stall_while_busy", {31'b0, bad}, 32'd0);
    check("mfhi_stall_done", {31'b0, stall}, 32'd0);
    check("mfhi_rdv_done", {31'b0, rd_valid}, 32'd1);
    check("mfhi_done_pulse", {31'b0, done}, 32'd1);
    @(posedge clk); #1; valid = 1'b0; funct = 6'h00;

    // mthi while idle, then read back
    @(posedge clk); #1; valid = 1'b1; funct = MTHI; rs = 32'hA5A5_A5A5;
    @(negedge clk);
    check("mthi_stall", {31'b0, stall}, 32'd0);
    check("mthi_busy", {31'b0, busy}, 32'd0);
    read_hilo(32'hA5A5_A5A5, 32'h0000_0000);

    // ignored code and mtlo presented while busy
    @(posedge clk); #1; valid = 1'b1; funct = MULT; rs = 32'd2; rt = 32'd3;
    @(posedge clk); #1; funct = 6'h20;
    @(negedge clk);
    check("ignored_no_stall", {31'b0, stall}, 32'd0);
    check("ignored_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1; funct = MTLO; rs = 32'hDEAD_0000;
    bad = 1'b0; cyc = 0;
    @(negedge clk);
    while (busy && cyc < 100) begin
      if (stall !== 1'b1) bad = 1'b1;
      cyc++;
      @(negedge clk);
    end
    check("mtlo_stall_while_busy", {31'b0, bad}, 32'd0);
    check("mtlo_stall_done", {31'b0, stall}, 32'd0);
    @(posedge clk); #1; funct = MFLO; exp_q.push_back(32'hDEAD_0000);
    @(posedge clk); #1; funct = MFHI; exp_q.push_back(32'h0000_0000);
    @(posedge clk); #1; valid = 1'b0; funct = 6'h00;

    // reset in the middle of a divide
    @(posedge clk); #1; valid = 1'b1; funct = DIV; rs = 32'd100; rt = 32'd7;
    @(posedge clk); #1; valid = 1'b0; funct = 6'h00;
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", {31'b0, seen}, 32'd0);
    read_hilo(32'd0, 32'd0);
    run_op(MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit_r0.md
Name: mult_div_unit_r0

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ALU controller.
- Consumes the resolved ALUfunct code and register operands, and owns the architectural HI/LO registers.
- Executes mult/multu/div/divu over multiple cycles and services mfhi/mflo/mthi/mtlo.
- Raises a pipeline stall while a result is pending.

Parameters:
DATA_WIDTH, 32, operand/HI/LO width
ALUFUNCT_WIDTH, 6, width of ALUfunct code (matches ALU controller output)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
valid  input  1  an instruction with a valid ALUfunct is in EX this cycle
ALUfunct  input  ALUFUNCT_WIDTH  resolved function code from ALU controller
rs_data  input  DATA_WIDTH  operand A (multiplicand/dividend, mthi/mtlo source)
rt_data  input  DATA_WIDTH  operand B (multiplier/divisor)
stall  output  1  hold the pipeline; the current instruction is not accepted
busy  output  1  an operation is in flight (state != IDLE)
done  output  1  one-cycle pulse: HI/LO updated by a completed mult/div
rd_data  output  DATA_WIDTH  HI for mfhi, LO for mflo, else 0 (combinational)
rd_valid  output  1  rd_data is valid this cycle

Behaviour:
- Codes handled:
  - mfhi 0x10, mthi 0x11, mflo 0x12, mtlo 0x13.
  - mult 0x18, multu 0x19, div 0x1A, divu 0x1B.
  - All other codes are ignored: no stall, no state change.
- Reset: state=IDLE, HI=0, LO=0, counter=0; busy=0, done=0, stall=0, rd_valid=0, rd_data=0. Reset mid-operation aborts the op with no HI/LO write.
- States: IDLE, RUN, FIX.
- IDLE:
  - valid & mult-class code -> latch operands. Signed ops latch absolute values plus result sign flags. Load counter=DATA_WIDTH, go to RUN.
  - valid & mthi -> HI<=rs_data. valid & mtlo -> LO<=rs_data. Both apply at the same edge; no busy.
- RUN: one iteration per cycle, counter decrements; counter reaches 0 -> FIX.
  - Multiply: shift-add, 2*DATA_WIDTH-bit product.
  - Divide: restoring, 1 quotient bit per cycle.
- FIX:
  - Apply sign correction.
  - Multiply: negate the full 64-bit product if signs differ.
  - Divide: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Write HI (product high / remainder) and LO (product low / quotient). Go to IDLE.
  - done=1 in the cycle following the FIX edge.
- Latency: accept at edge E; HI/LO written at edge E+DATA_WIDTH+1 (E+33 at default). busy high from after E until that write edge; done high for the cycle after it. Latency is fixed for every operand value, including divide-by-zero.
- Divide by zero (rt_data=0 at accept, div or divu): result forced to HI=rs_data, LO={DATA_WIDTH{1'b1}}.
- Signed overflow: div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. Natural result; no trap.
- stall = valid & busy & (any of the 8 codes above). A mult/div/mthi/mtlo presented while busy is not accepted and not queued; it is accepted the first cycle busy=0.
- rd_valid = valid & !busy & (mfhi|mflo). rd_data shows the current HI/LO, so a value written at an edge is visible the next cycle.
- Simultaneous events: at the done cycle busy=0, so a waiting mfhi reads the new HI in that cycle. A new mult in the done cycle is accepted normally.

Test Plan:
- multu rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy 33 cycles, done pulse, then mfhi=0xFFFFFFFE, mflo=0x00000001.
- mult rs=0xFFFFFFFD(-3) rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; div rs=0xFFFFFFF9(-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu rs=0x1234 rt=0 -> same 33-cycle latency, HI=0x00001234, LO=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mfhi presented continuously from the cycle after a mult accept -> stall=1, rd_valid=0 until the done cycle; in the done cycle stall=0, rd_valid=1, rd_data=new HI.
- mthi rs=0xA5A5A5A5 then mflo/mfhi idle -> HI reads 0xA5A5A5A5 the next cycle, no stall; mtlo presented while busy -> stall=1, LO unchanged until accepted.
- rst asserted 10 cycles into a div -> next cycle busy=0, done never pulses, HI=LO=0; a subsequent multu 6*7 -> LO=42, HI=0.
